addrdec_cfg_sequencer: RTL and testbench

Serialises whole-window update requests into the byte-wide configuration write port of the Dock I/O address decoder: `cfg_we`, `cfg_addr` and `cfg_wdata`, with the decoder's `cfg_clk` tied to `clk`. Each window update is ordered so that the decoder never matches a half-written window. The window is disabled first, then rewritten, then re-enabled. Writes are held off while a Host I/O cycle is in progress. A clear-all command disables every window.

---
 rtl/addrdec_cfg_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_addrdec_cfg_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/addrdec_cfg_sequencer.sv
// addrdec_cfg_sequencer: serialises whole-window updates into the byte-wide
// configuration port of the Dock I/O address decoder. A load disables the
// window, rewrites base/mask/slot, then re-enables it with the new op byte.
// A clear-all zeroes the op byte of every window. Writes are held off while
// the synchronised Host /IORQ shows a bus cycle in progress.
module addrdec_cfg_sequencer #(
  parameter int ADDR_W    = 32,
  parameter int NUM_WIN   = 16,
  parameter int NUM_SLOTS = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_cmd,
  input  logic [3:0]        req_win,
  input  logic [ADDR_W-1:0] req_base,
  input  logic [ADDR_W-1:0] req_mask,
  input  logic [2:0]        req_slot,
  input  logic [7:0]        req_op,
  input  logic              iorq_n,
  output logic              cfg_we,
  output logic [7:0]        cfg_addr,
  output logic [7:0]        cfg_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int AB = ADDR_W / 8;
  localparam int S  = 2 * AB + 2;

  localparam logic [7:0] STRIDE8  = 8'(S);
  localparam logic [7:0] AB8      = 8'(AB);
  localparam logic [3:0] AB_LAST  = 4'(AB - 1);
  localparam logic [3:0] WIN_LAST = 4'(NUM_WIN - 1);
  localparam logic [4:0] NWIN5    = 5'(NUM_WIN);
  localparam logic [3:0] NSLOT4   = 4'(NUM_SLOTS);

  // state names the byte currently presented on the cfg port; cfg_we tells
  // whether that byte is actually being written this cycle
  typedef enum logic [2:0] {
    IDLE, DIS, BASE, MASK, SLOT, EN, CLR, FIN
  } state_t;

  state_t            state, nstate;
  logic [3:0]        idx, nidx;

  logic [3:0]        r_win;
  logic [ADDR_W-1:0] r_base, r_mask;
  logic [2:0]        r_slot;
  logic [7:0]        r_op;

  logic              sync1, sync2;
  logic              bus_idle;

  logic              req_bad;
  logic              accept;

  logic [3:0]        f_win;
  logic [ADDR_W-1:0] f_base, f_mask;
  logic [2:0]        f_slot;
  logic [7:0]        f_op;

  logic [7:0]        wbase;
  logic [7:0]        base_byte, mask_byte;
  logic [7:0]        n_addr, n_data;
  logic              n_write;

  assign bus_idle  = sync2;
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign req_bad   = !req_cmd &&
                     (({1'b0, req_win} >= NWIN5) || ({1'b0, req_slot} >= NSLOT4));
  assign accept    = req_ready && req_valid;

  // next byte position: advance only once the presented byte was written
  always_comb begin
    nstate = state;
    nidx   = idx;
    f_win  = r_win;
    f_base = r_base;
    f_mask = r_mask;
    f_slot = r_slot;
    f_op   = r_op;
    if (state == IDLE) begin
      // first byte goes out on the acceptance edge, so use the live request
      f_win  = req_win;
      f_base = req_base;
      f_mask = req_mask;
      f_slot = req_slot;
      f_op   = req_op;
      if (req_valid && !req_bad) begin
        nstate = req_cmd ? CLR : DIS;
        nidx   = 4'd0;
      end
    end else if (state == FIN) begin
      nstate = IDLE;
    end else if (cfg_we) begin
      case (state)
        DIS:  begin nstate = BASE; nidx = 4'd0; end
        BASE: if (idx == AB_LAST) begin nstate = MASK; nidx = 4'd0; end
              else nidx = idx + 4'd1;
        MASK: if (idx == AB_LAST) begin nstate = SLOT; nidx = 4'd0; end
              else nidx = idx + 4'd1;
        SLOT: nstate = EN;
        EN:   nstate = FIN;
        CLR:  if (idx == WIN_LAST) nstate = FIN;
              else nidx = idx + 4'd1;
        default: nstate = IDLE;
      endcase
    end
  end

  // pick the base/mask byte addressed by the byte counter
  always_comb begin
    base_byte = 8'h00;
    mask_byte = 8'h00;
    for (int i = 0; i < AB; i++) begin
      if (nidx == i[3:0]) begin
        base_byte = f_base[8*i +: 8];
        mask_byte = f_mask[8*i +: 8];
      end
    end
  end

  // config map: window w occupies bytes w*S .. w*S+S-1
  always_comb begin
    wbase   = {4'b0, f_win} * STRIDE8;
    n_addr  = 8'h00;
    n_data  = 8'h00;
    n_write = 1'b1;
    case (nstate)
      DIS:  begin n_addr = wbase + STRIDE8 - 8'd1;       n_data = 8'h00;          end
      BASE: begin n_addr = wbase + {4'b0, nidx};         n_data = base_byte;      end
      MASK: begin n_addr = wbase + AB8 + {4'b0, nidx};   n_data = mask_byte;      end
      SLOT: begin n_addr = wbase + STRIDE8 - 8'd2;       n_data = {5'b0, f_slot}; end
      EN:   begin n_addr = wbase + STRIDE8 - 8'd1;       n_data = f_op;           end
      CLR:  begin n_addr = ({4'b0, nidx} * STRIDE8) + STRIDE8 - 8'd1;
                  n_data = 8'h00; end
      default: n_write = 1'b0;
    endcase
  end

  // Host /IORQ synchroniser; reset to idle-bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= iorq_n;
      sync2 <= sync1;
    end
  end

  // sequencer state, request capture and registered cfg port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 4'd0;
      r_win     <= 4'd0;
      r_base    <= '0;
      r_mask    <= '0;
      r_slot    <= 3'd0;
      r_op      <= 8'h00;
      cfg_we    <= 1'b0;
      cfg_addr  <= 8'h00;
      cfg_wdata <= 8'h00;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= nstate;
      idx   <= nidx;
      done  <= (nstate == FIN);
      err   <= accept && req_bad;
      if (accept && !req_bad) begin
        r_win  <= req_win;
        r_base <= req_base;
        r_mask <= req_mask;
        r_slot <= req_slot;
        r_op   <= req_op;
      end
      if (n_write) begin
        // a busy host bus pauses the write; address/data stay put
        cfg_we    <= bus_idle;
        cfg_addr  <= n_addr;
        cfg_wdata <= n_data;
      end else begin
        cfg_we <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_addrdec_cfg_sequencer.sv
// Bench for addrdec_cfg_sequencer: directed scenarios plus randomised loads,
// clears and rejected requests against a byte-sequence reference model.
module tb_addrdec_cfg_sequencer;
  localparam int ADDR_W    = 32;
  localparam int NUM_WIN   = 16;
  localparam int NUM_SLOTS = 5;
  localparam int AB        = ADDR_W / 8;
  localparam int S         = 2 * AB + 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_cmd = 1'b0;
  logic [3:0]        req_win = 4'd0;
  logic [ADDR_W-1:0] req_base = '0;
  logic [ADDR_W-1:0] req_mask = '0;
  logic [2:0]        req_slot = 3'd0;
  logic [7:0]        req_op = 8'h00;
  logic              iorq_n = 1'b1;
  logic              cfg_we;
  logic [7:0]        cfg_addr, cfg_wdata;
  logic              busy, done, err;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];

  addrdec_cfg_sequencer #(.ADDR_W(ADDR_W), .NUM_WIN(NUM_WIN), .NUM_SLOTS(NUM_SLOTS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_win(req_win), .req_base(req_base), .req_mask(req_mask),
    .req_slot(req_slot), .req_op(req_op), .iorq_n(iorq_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // reference: expected {addr,data} list of one window load
  task automatic model_load(input logic [3:0] w, input logic [31:0] b, input logic [31:0] m,
                            input logic [2:0] sl, input logic [7:0] op);
    int wa;
    wa = int'(w) * S;
    exp_q.push_back({8'(wa + S - 1), 8'h00});
    for (int i = 0; i < AB; i++) exp_q.push_back({8'(wa + i), 8'(b >> (8 * i))});
    for (int i = 0; i < AB; i++) exp_q.push_back({8'(wa + AB + i), 8'(m >> (8 * i))});
    exp_q.push_back({8'(wa + S - 2), {5'b0, sl}});
    exp_q.push_back({8'(wa + S - 1), op});
  endtask

  task automatic model_clear();
    for (int w = 0; w < NUM_WIN; w++) exp_q.push_back({8'(w * S + S - 1), 8'h00});
  endtask

  // present one request for exactly one clock edge
  task automatic issue(input logic cmd, input logic [3:0] w, input logic [31:0] b,
                       input logic [31:0] m, input logic [2:0] sl, input logic [7:0] op);
    @(negedge clk);
    req_cmd = cmd; req_win = w; req_base = b; req_mask = m; req_slot = sl; req_op = op;
    req_valid = 1'b1;
    @(posedge clk);
  endtask

  // record writes cycle by cycle after acceptance; optional /IORQ stall
  task automatic collect(input int max_c, input int stall_at, input int stall_len,
                         output int done_c, output int busy_bad, output int err_c);
    int nw, left;
    bit stalled;
    nw = 0; left = 0; stalled = 0;
    done_c = -1; busy_bad = 0; err_c = 0;
    obs_q.delete();
    for (int c = 1; c <= max_c; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (cfg_we) begin obs_q.push_back({cfg_addr, cfg_wdata}); nw++; end
      if (err) err_c++;
      if (!busy) busy_bad++;
      if (left > 0) begin
        left--;
        if (left == 0) iorq_n = 1'b1;
      end else if (stall_len > 0 && !stalled && nw == stall_at) begin
        iorq_n = 1'b0; left = stall_len; stalled = 1;
      end
      if (done) begin done_c = c; break; end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (cfg_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", cfg_we); end
    checks++; if (cfg_addr !== 8'h00 || cfg_wdata !== 8'h00) begin errors++;
      $display("FAIL reset_addr_data got %h/%h exp 00/00", cfg_addr, cfg_wdata); end
    checks++; if ({busy, done, err} !== 3'b000) begin errors++;
      $display("FAIL reset_flags got %b exp 000", {busy, done, err}); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic cmp_seq(input string name);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_count got %0d exp %0d", name, obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL %s_byte%0d got %h exp %h", name, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_load_basic();
    int dc, bb, ec;
    exp_q.delete();
    model_load(4'd2, 32'h0000_0300, 32'hFFFF_FFF0, 3'd1, 8'h03);
    issue(1'b0, 4'd2, 32'h0000_0300, 32'hFFFF_FFF0, 3'd1, 8'h03);
    collect(40, 0, 0, dc, bb, ec);
    cmp_seq("load");
    checks++; if (dc != 12) begin errors++; $display("FAIL load_done_cycle got %0d exp 12", dc); end
    checks++; if (bb != 0) begin errors++; $display("FAIL load_busy got %0d idle cycles exp 0", bb); end
  endtask

  task automatic test_stall();
    int dc, bb, ec;
    exp_q.delete();
    model_load(4'd2, 32'h0000_0300, 32'hFFFF_FFF0, 3'd1, 8'h03);
    issue(1'b0, 4'd2, 32'h0000_0300, 32'hFFFF_FFF0, 3'd1, 8'h03);
    collect(60, 3, 5, dc, bb, ec);
    cmp_seq("stall");
    checks++; if (dc != 17) begin errors++; $display("FAIL stall_done_cycle got %0d exp 17", dc); end
  endtask

  task automatic test_clear();
    int dc, bb, ec;
    exp_q.delete();
    model_clear();
    issue(1'b1, 4'd0, 32'h0, 32'h0, 3'd0, 8'h00);
    collect(60, 0, 0, dc, bb, ec);
    cmp_seq("clear");
    checks++; if (dc != NUM_WIN + 1) begin errors++; $display("FAIL clear_done_cycle got %0d exp %0d", dc, NUM_WIN + 1); end
    checks++; if (bb != 0) begin errors++; $display("FAIL clear_busy got %0d idle cycles exp 0", bb); end
  endtask

  task automatic test_err();
    int dc, bb, ec;
    logic [3:0] wv[2];
    logic [2:0] sv[2];
    wv[0] = 4'hF; sv[0] = 3'd5;
    wv[1] = 4'h0; sv[1] = 3'd7;
    for (int k = 0; k < 2; k++) begin
      issue(1'b0, wv[k], 32'h1234_5678, 32'hFFFF_0000, sv[k], 8'h11);
      collect(6, 0, 0, dc, bb, ec);
      checks++; if (ec != 1) begin errors++; $display("FAIL err%0d_pulses got %0d exp 1", k, ec); end
      checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL err%0d_writes got %0d exp 0", k, obs_q.size()); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL err%0d_ready got %b exp 1", k, req_ready); end
    end
  endtask

  task automatic test_reset_mid();
    int nw, late;
    nw = 0; late = 0;
    issue(1'b0, 4'd5, 32'hAABB_CCDD, 32'hFFFF_FF00, 3'd2, 8'h07);
    for (int c = 1; c <= 20 && nw < 4; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (cfg_we) nw++;
    end
    rst_n = 1'b0;
    #1;
    checks++; if ({cfg_we, busy, done, err} !== 4'b0000) begin errors++;
      $display("FAIL rstmid_flags got %b exp 0000", {cfg_we, busy, done, err}); end
    checks++; if (cfg_addr !== 8'h00 || cfg_wdata !== 8'h00) begin errors++;
      $display("FAIL rstmid_addr_data got %h/%h exp 00/00", cfg_addr, cfg_wdata); end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (cfg_we || busy) late++;
    end
    checks++; if (late != 0) begin errors++; $display("FAIL rstmid_activity got %0d cycles exp 0", late); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_back_to_back();
    int d1, d2, nd;
    d1 = -1; d2 = -1; nd = 0;
    exp_q.delete(); obs_q.delete();
    model_load(4'd7, 32'h0102_0304, 32'hF0F0_F0F0, 3'd4, 8'h5A);
    model_load(4'd8, 32'hDEAD_BEEF, 32'h0000_FFFF, 3'd0, 8'hC3);
    issue(1'b0, 4'd7, 32'h0102_0304, 32'hF0F0_F0F0, 3'd4, 8'h5A);
    for (int c = 1; c <= 60 && nd < 2; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_win = 4'd8; req_base = 32'hDEAD_BEEF; req_mask = 32'h0000_FFFF;
        req_slot = 3'd0; req_op = 8'hC3;
      end
      if (c == 14) req_valid = 1'b0;
      if (cfg_we) obs_q.push_back({cfg_addr, cfg_wdata});
      if (c <= 13) begin
        checks++;
        if (req_ready !== (c == 13)) begin errors++;
          $display("FAIL b2b_ready_c%0d got %b exp %b", c, req_ready, (c == 13)); end
      end
      if (done) begin
        nd++;
        if (nd == 1) d1 = c; else d2 = c;
      end
    end
    req_valid = 1'b0;
    cmp_seq("b2b");
    checks++; if (d1 != 12 || d2 != 25) begin errors++;
      $display("FAIL b2b_done got %0d,%0d exp 12,25", d1, d2); end
  endtask

  task automatic test_random();
    int dc, bb, ec, sa, sl_len, nwr;
    logic cmd;
    logic [3:0] w;
    logic [2:0] sl;
    logic [31:0] b, m;
    logic [7:0] op;
    bit bad;
    for (int it = 0; it < 24; it++) begin
      cmd = ($urandom_range(0, 4) == 0);
      w = 4'($urandom_range(0, 15));
      sl = 3'($urandom_range(0, 7));
      b = $urandom; m = $urandom; op = 8'($urandom);
      sa = $urandom_range(1, 8);
      sl_len = $urandom_range(0, 6);
      bad = !cmd && (int'(w) >= NUM_WIN || int'(sl) >= NUM_SLOTS);
      exp_q.delete();
      if (cmd) model_clear();
      else if (!bad) model_load(w, b, m, sl, op);
      nwr = exp_q.size();
      issue(cmd, w, b, m, sl, op);
      if (bad) begin
        collect(6, 0, 0, dc, bb, ec);
        checks++; if (ec != 1 || obs_q.size() != 0) begin errors++;
          $display("FAIL rand%0d_reject got err %0d writes %0d exp 1 0", it, ec, obs_q.size()); end
      end else begin
        collect(80, sa, sl_len, dc, bb, ec);
        cmp_seq("rand");
        checks++; if (dc != nwr + 1 + sl_len) begin errors++;
          $display("FAIL rand%0d_done got %0d exp %0d", it, dc, nwr + 1 + sl_len); end
        checks++; if (ec != 0) begin errors++; $display("FAIL rand%0d_err got %0d exp 0", it, ec); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_stall();
    test_clear();
    test_err();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
